flag_branch_unit: RTL and testbench

- Sits directly downstream of the 8-bit magnitude comparator.
- Latches the comparator's one-hot GREATER/EQUAL/LESS result into a flag register.
- Evaluates conditional-branch codes against the latched flags and owns the program counter.
- On a taken branch it redirects PC and drives a fixed-length pipeline flush.

---
 rtl/flag_branch_unit_pkg.sv | 26 ++
 rtl/flag_branch_unit_cond_eval.sv | 25 ++
 rtl/flag_branch_unit.sv | 121 ++++++++++++
 tb/tb_flag_branch_unit.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/flag_branch_unit_pkg.sv
// rtl/flag_branch_unit_pkg.sv - shared condition codes, state encoding and flag indices
package flag_branch_unit_pkg;

   localparam logic [2:0] COND_ALWAYS = 3'b000;
   localparam logic [2:0] COND_EQ     = 3'b001;
   localparam logic [2:0] COND_NE     = 3'b010;
   localparam logic [2:0] COND_GT     = 3'b011;
   localparam logic [2:0] COND_LT     = 3'b100;
   localparam logic [2:0] COND_GE     = 3'b101;
   localparam logic [2:0] COND_LE     = 3'b110;
   localparam logic [2:0] COND_NEVER  = 3'b111;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_FLUSH = 1'b1
   } state_e;

   localparam int FLAG_G = 2;
   localparam int FLAG_E = 1;
   localparam int FLAG_L = 0;

   function automatic logic is_onehot3(input logic [2:0] v);
      return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
   endfunction

endpackage

// File: rtl/flag_branch_unit_cond_eval.sv
// rtl/flag_branch_unit_cond_eval.sv - combinational branch-condition evaluation on {G,E,L}
module cond_eval
   import flag_branch_unit_pkg::*;
(
   input  logic [2:0] flags,
   input  logic [2:0] cond,
   output logic       true
);

   always_comb begin
      true = 1'b0;
      case (cond)
         COND_ALWAYS: true = 1'b1;
         COND_EQ:     true = flags[FLAG_E];
         COND_NE:     true = ~flags[FLAG_E];
         COND_GT:     true = flags[FLAG_G];
         COND_LT:     true = flags[FLAG_L];
         COND_GE:     true = flags[FLAG_G] | flags[FLAG_E];
         COND_LE:     true = flags[FLAG_L] | flags[FLAG_E];
         COND_NEVER:  true = 1'b0;
         default:     true = 1'b0;
      endcase
   end

endmodule

// File: rtl/flag_branch_unit.sv
// rtl/flag_branch_unit.sv - flag register, PC and taken-branch flush FSM
// Optional macro FLAG_FWD_EN: same-cycle flag write is forwarded into branch evaluation.
module flag_branch_unit
   import flag_branch_unit_pkg::*;
#(
   parameter int                PC_W         = 8,
   parameter logic [PC_W-1:0]   RESET_PC     = '0,
   parameter int                FLUSH_CYCLES = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            greater_in,
   input  logic            equal_in,
   input  logic            less_in,
   input  logic            flag_we,
   input  logic            pc_en,
   input  logic            br_valid,
   input  logic [2:0]      br_cond,
   input  logic [PC_W-1:0] br_target,
   output logic [PC_W-1:0] PC,
   output logic [2:0]      FLAGS,
   output logic            TAKEN,
   output logic            FLUSH,
   output logic            BUSY,
   output logic            ERR
);

   localparam logic [3:0] FLUSH_INIT = (FLUSH_CYCLES > 0) ? 4'(FLUSH_CYCLES - 1) : 4'd0;

   state_e          state_q, state_d;
   logic [3:0]      cnt_q, cnt_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [2:0]      flags_q, flags_d;
   logic            taken_q, taken_d;
   logic            flush_q, flush_d;
   logic            err_q, err_d;

   logic [2:0]      gel_in;
   logic [2:0]      eval_flags;
   logic            cond_true;

   assign gel_in = {greater_in, equal_in, less_in};

`ifdef FLAG_FWD_EN
   assign eval_flags = flag_we ? gel_in : flags_q;
`else
   assign eval_flags = flags_q;
`endif

   cond_eval u_cond_eval (
      .flags (eval_flags),
      .cond  (br_cond),
      .true  (cond_true)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pc_d    = pc_q;
      taken_d = 1'b0;
      flush_d = flush_q;
      flags_d = flag_we ? gel_in : flags_q;
      err_d   = err_q | (flag_we & ~is_onehot3(gel_in));
      case (state_q)
         ST_RUN: begin
            if (br_valid && cond_true) begin
               pc_d    = br_target;
               taken_d = 1'b1;
               if (FLUSH_CYCLES > 0) begin
                  state_d = ST_FLUSH;
                  flush_d = 1'b1;
                  cnt_d   = FLUSH_INIT;
               end
            end else if (pc_en) begin
               pc_d = pc_q + PC_W'(1);
            end
         end
         // Wrong-path pc_en/br_valid are dropped while flushing.
         ST_FLUSH: begin
            if (cnt_q == 4'd0) begin
               state_d = ST_RUN;
               flush_d = 1'b0;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: begin
            state_d = ST_RUN;
            flush_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_RUN;
         cnt_q   <= 4'd0;
         pc_q    <= RESET_PC;
         flags_q <= 3'b000;
         taken_q <= 1'b0;
         flush_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pc_q    <= pc_d;
         flags_q <= flags_d;
         taken_q <= taken_d;
         flush_q <= flush_d;
         err_q   <= err_d;
      end
   end

   assign PC    = pc_q;
   assign FLAGS = flags_q;
   assign TAKEN = taken_q;
   assign FLUSH = flush_q;
   assign BUSY  = flush_q;
   assign ERR   = err_q;

endmodule

// File: tb/tb_flag_branch_unit.sv
// tb/tb_flag_branch_unit.sv - table-driven scoreboard bench for flag_branch_unit
module tb_flag_branch_unit;

   typedef struct {
      logic       rst;
      logic       we;
      logic [2:0] gel;
      logic       pc_en;
      logic       bv;
      logic [2:0] cond;
      logic [7:0] tgt;
      logic [7:0] pc;
      logic [2:0] flags;
      logic       taken;
      logic       flush;
      logic       err;
   } vec_t;

   typedef struct {
      logic [7:0] pc;
      logic [2:0] flags;
      logic       taken;
      logic       flush;
      logic       err;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst, greater_in, equal_in, less_in, flag_we, pc_en, br_valid;
   logic [2:0] br_cond;
   logic [7:0] br_target;
   logic [7:0] PC;
   logic [2:0] FLAGS;
   logic       TAKEN, FLUSH, BUSY, ERR;

   int total = 0;
   int bad   = 0;

   vec_t tbl[$];
   exp_t sb[$];

   flag_branch_unit #(.PC_W(8), .RESET_PC(8'h00), .FLUSH_CYCLES(2)) dut (
      .clk(clk), .rst(rst),
      .greater_in(greater_in), .equal_in(equal_in), .less_in(less_in),
      .flag_we(flag_we), .pc_en(pc_en), .br_valid(br_valid),
      .br_cond(br_cond), .br_target(br_target),
      .PC(PC), .FLAGS(FLAGS), .TAKEN(TAKEN), .FLUSH(FLUSH), .BUSY(BUSY), .ERR(ERR)
   );

   always #5 clk = ~clk;

   task automatic add(input logic r, input logic we, input logic [2:0] gel, input logic pe,
                      input logic bv, input logic [2:0] cond, input logic [7:0] tgt,
                      input logic [7:0] pc, input logic [2:0] fl, input logic tk,
                      input logic fs, input logic er);
      vec_t v;
      v.rst = r; v.we = we; v.gel = gel; v.pc_en = pe; v.bv = bv; v.cond = cond; v.tgt = tgt;
      v.pc = pc; v.flags = fl; v.taken = tk; v.flush = fs; v.err = er;
      tbl.push_back(v);
   endtask

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s row %0d: got %0h want %0h", name, idx, act, exp);
      end
   endtask

   task automatic apply(input int idx, input vec_t v);
      exp_t e;
      rst = v.rst; flag_we = v.we;
      {greater_in, equal_in, less_in} = v.gel;
      pc_en = v.pc_en; br_valid = v.bv; br_cond = v.cond; br_target = v.tgt;
      e.pc = v.pc; e.flags = v.flags; e.taken = v.taken; e.flush = v.flush; e.err = v.err;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         chk("scoreboard_empty", idx, 32'd1, 32'd0);
      end else begin
         e = sb.pop_front();
         chk("PC",    idx, 32'(PC),    32'(e.pc));
         chk("FLAGS", idx, 32'(FLAGS), 32'(e.flags));
         chk("TAKEN", idx, 32'(TAKEN), 32'(e.taken));
         chk("FLUSH", idx, 32'(FLUSH), 32'(e.flush));
         chk("BUSY",  idx, 32'(BUSY),  32'(e.flush));
         chk("ERR",   idx, 32'(ERR),   32'(e.err));
      end
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; flag_we = 1'b0; {greater_in, equal_in, less_in} = 3'b000;
      pc_en = 1'b0; br_valid = 1'b0; br_cond = 3'b000; br_target = 8'h00;

      //   rst we  gel    pe bv cond    tgt     pc     flags  tk fs er
      add(1, 0, 3'b000, 1, 0, 3'b000, 8'h00, 8'h00, 3'b000, 0, 0, 0);
      add(0, 0, 3'b000, 1, 0, 3'b000, 8'h00, 8'h01, 3'b000, 0, 0, 0);
      add(0, 0, 3'b000, 1, 0, 3'b000, 8'h00, 8'h02, 3'b000, 0, 0, 0);
      add(0, 0, 3'b000, 1, 0, 3'b000, 8'h00, 8'h03, 3'b000, 0, 0, 0);
      add(0, 1, 3'b010, 0, 0, 3'b000, 8'h00, 8'h03, 3'b010, 0, 0, 0);
      add(0, 0, 3'b000, 1, 1, 3'b001, 8'h40, 8'h40, 3'b010, 1, 1, 0);
      add(0, 0, 3'b000, 1, 0, 3'b000, 8'h00, 8'h40, 3'b010, 0, 1, 0);
      add(0, 0, 3'b000, 1, 0, 3'b000, 8'h00, 8'h40, 3'b010, 0, 0, 0);
      add(0, 0, 3'b000, 1, 0, 3'b000, 8'h00, 8'h41, 3'b010, 0, 0, 0);
      // FLAGS=100, reach PC=5, LT not taken
      add(1, 0, 3'b000, 0, 0, 3'b000, 8'h00, 8'h00, 3'b000, 0, 0, 0);
      add(0, 1, 3'b100, 1, 0, 3'b000, 8'h00, 8'h01, 3'b100, 0, 0, 0);
      add(0, 0, 3'b000, 1, 0, 3'b000, 8'h00, 8'h02, 3'b100, 0, 0, 0);
      add(0, 0, 3'b000, 1, 0, 3'b000, 8'h00, 8'h03, 3'b100, 0, 0, 0);
      add(0, 0, 3'b000, 1, 0, 3'b000, 8'h00, 8'h04, 3'b100, 0, 0, 0);
      add(0, 0, 3'b000, 1, 0, 3'b000, 8'h00, 8'h05, 3'b100, 0, 0, 0);
      add(0, 0, 3'b000, 1, 1, 3'b100, 8'h10, 8'h06, 3'b100, 0, 0, 0);
      // same-cycle flag write with LT branch
`ifdef FLAG_FWD_EN
      add(0, 1, 3'b001, 0, 1, 3'b100, 8'h20, 8'h20, 3'b001, 1, 1, 0);
      add(0, 0, 3'b000, 0, 0, 3'b000, 8'h00, 8'h20, 3'b001, 0, 1, 0);
      add(0, 0, 3'b000, 0, 0, 3'b000, 8'h00, 8'h20, 3'b001, 0, 0, 0);
`else
      add(0, 1, 3'b001, 0, 1, 3'b100, 8'h20, 8'h06, 3'b001, 0, 0, 0);
      add(0, 0, 3'b000, 0, 0, 3'b000, 8'h00, 8'h06, 3'b001, 0, 0, 0);
      add(0, 0, 3'b000, 0, 0, 3'b000, 8'h00, 8'h06, 3'b001, 0, 0, 0);
`endif
      // wrap, ignored branch during flush, reset mid-flush
      add(1, 0, 3'b000, 0, 0, 3'b000, 8'h00, 8'h00, 3'b000, 0, 0, 0);
      add(0, 0, 3'b000, 0, 1, 3'b000, 8'hFF, 8'hFF, 3'b000, 1, 1, 0);
      add(0, 0, 3'b000, 0, 0, 3'b000, 8'h00, 8'hFF, 3'b000, 0, 1, 0);
      add(0, 0, 3'b000, 0, 0, 3'b000, 8'h00, 8'hFF, 3'b000, 0, 0, 0);
      add(0, 0, 3'b000, 1, 0, 3'b000, 8'h00, 8'h00, 3'b000, 0, 0, 0);
      add(0, 0, 3'b000, 0, 1, 3'b000, 8'h30, 8'h30, 3'b000, 1, 1, 0);
      add(0, 0, 3'b000, 1, 1, 3'b000, 8'h77, 8'h30, 3'b000, 0, 1, 0);
      add(0, 0, 3'b000, 0, 0, 3'b000, 8'h00, 8'h30, 3'b000, 0, 0, 0);
      add(0, 0, 3'b000, 0, 1, 3'b010, 8'h50, 8'h50, 3'b000, 1, 1, 0);
      add(1, 0, 3'b000, 1, 1, 3'b000, 8'h66, 8'h00, 3'b000, 0, 0, 0);
      add(0, 0, 3'b000, 1, 0, 3'b000, 8'h00, 8'h01, 3'b000, 0, 0, 0);
      add(0, 0, 3'b000, 1, 1, 3'b111, 8'h09, 8'h02, 3'b000, 0, 0, 0);
      // non-one-hot write sets sticky ERR
      add(0, 1, 3'b110, 0, 0, 3'b000, 8'h00, 8'h02, 3'b110, 0, 0, 1);
      add(0, 1, 3'b010, 0, 0, 3'b000, 8'h00, 8'h02, 3'b010, 0, 0, 1);
      add(0, 0, 3'b000, 0, 1, 3'b101, 8'h12, 8'h12, 3'b010, 1, 1, 1);
      add(0, 0, 3'b000, 0, 0, 3'b000, 8'h00, 8'h12, 3'b010, 0, 1, 1);
      add(0, 0, 3'b000, 0, 0, 3'b000, 8'h00, 8'h12, 3'b010, 0, 0, 1);
      add(0, 1, 3'b001, 1, 1, 3'b011, 8'h44, 8'h13, 3'b001, 0, 0, 1);
      add(0, 0, 3'b000, 0, 1, 3'b110, 8'h03, 8'h03, 3'b001, 1, 1, 1);
      add(0, 1, 3'b100, 0, 0, 3'b000, 8'h00, 8'h03, 3'b100, 0, 1, 1);
      add(0, 0, 3'b000, 0, 0, 3'b000, 8'h00, 8'h03, 3'b100, 0, 0, 1);
      add(1, 0, 3'b000, 0, 0, 3'b000, 8'h00, 8'h00, 3'b000, 0, 0, 0);

      for (int i = 0; i < tbl.size(); i++) begin
         apply(i, tbl[i]);
      end

      // self-loop: branch to current PC, then resume one past it
      begin
         vec_t v;
         v = '{rst:0, we:0, gel:3'b000, pc_en:1, bv:1, cond:3'b000, tgt:8'h00,
               pc:8'h00, flags:3'b000, taken:1, flush:1, err:0};
         apply(100, v);
         v.bv = 1'b0; v.taken = 1'b0;
         apply(101, v);
         v.flush = 1'b0;
         apply(102, v);
         v.pc = 8'h01;
         apply(103, v);
      end

      if (sb.size() != 0) chk("scoreboard_leftover", 0, 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
